// File: rtl/ropuf_pkg.sv
// Shared RO-PUF definitions: measurement FSM encoding and default count/window sizing
// used by the window counter, the count comparator and the challenge controller.
package ropuf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        LATCH = 2'd3
    } ro_state_t;

    localparam int RO_CNT_W  = 4;
    localparam int RO_WIN_W  = 8;
    localparam int RO_WINDOW = 200;
    localparam int RO_FLUSH  = 3;

endpackage

// File: rtl/ro_edge_sync.sv
// 2-flop synchronizer plus previous-value flop; edge_pulse is one clk per synchronized rise.
// Latency: a rise sampled at edge k pulses in the cycle after edge k+1; no backpressure.
module ro_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic edge_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign edge_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/ro_count_window.sv
// Gates an RO pair for WINDOW clk cycles and reports saturating rising-edge counts.
// Latency: start on edge N gives done in cycle N+1+FLUSH+WINDOW; start ignored while busy.
module ro_count_window
    import ropuf_pkg::*;
#(
    parameter int CNT_W  = RO_CNT_W,
    parameter int WIN_W  = RO_WIN_W,
    parameter int WINDOW = RO_WINDOW,
    parameter int FLUSH  = RO_FLUSH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ro0,
    input  logic             ro1,
    output logic             ro_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count0,
    output logic [CNT_W-1:0] count1,
    output logic             sat0,
    output logic             sat1
);

    localparam logic [WIN_W-1:0] FLUSH_LAST = WIN_W'(FLUSH - 1);
    localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    ro_state_t               r_state;
    ro_state_t               w_next;
    logic [WIN_W-1:0]        r_timer;
    logic [1:0][CNT_W-1:0]   r_cnt;
    logic [1:0]              r_sat;
    logic [1:0]              w_edge;
    logic                    w_clear;

    ro_edge_sync u_sync0 (
        .clk        (clk),
        .reset      (reset),
        .async_in   (ro0),
        .edge_pulse (w_edge[0])
    );

    ro_edge_sync u_sync1 (
        .clk        (clk),
        .reset      (reset),
        .async_in   (ro1),
        .edge_pulse (w_edge[1])
    );

    assign w_clear = (r_state == IDLE) && start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        ro_en  = 1'b0;
        busy   = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = ARM;
                end
            end
            ARM: begin
                ro_en = 1'b1;
                if (r_timer == FLUSH_LAST) begin
                    w_next = COUNT;
                end
            end
            COUNT: begin
                ro_en = 1'b1;
                if (r_timer == WIN_LAST) begin
                    w_next = LATCH;
                end
            end
            LATCH: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Timer restarts from 0 on entry to both ARM and COUNT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else begin
            case (r_state)
                ARM:     r_timer <= (r_timer == FLUSH_LAST) ? '0 : r_timer + 1'b1;
                COUNT:   r_timer <= r_timer + 1'b1;
                default: r_timer <= '0;
            endcase
        end
    end

    // The sticky flag sets as the counter reaches all-ones, so it is set whenever the count pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_sat <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_clear) begin
                    r_cnt[i] <= '0;
                    r_sat[i] <= 1'b0;
                end else if ((r_state == COUNT) && w_edge[i]) begin
                    if (r_cnt[i] != CNT_MAX) begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                    if (r_cnt[i] >= CNT_MAX - 1'b1) begin
                        r_sat[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done   <= 1'b0;
            count0 <= '0;
            count1 <= '0;
            sat0   <= 1'b0;
            sat1   <= 1'b0;
        end else begin
            done <= (r_state == LATCH);
            if (r_state == LATCH) begin
                count0 <= r_cnt[0];
                count1 <= r_cnt[1];
                sat0   <= r_sat[0];
                sat1   <= r_sat[1];
            end
        end
    end

endmodule

// File: tb/tb_ro_count_window.sv
// Two instances (WINDOW 16 and 64, FLUSH 3) share one stimulus stream and are
// compared every cycle against a sample-history model of the measurement rules.
module tb_ro_count_window;

    localparam int FL = 3;
    localparam int NC = 32768;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic ro0 = 1'b0;
    logic ro1 = 1'b0;

    logic       ro_en_o [2];
    logic       busy_o  [2];
    logic       done_o  [2];
    logic [3:0] c0_o    [2];
    logic [3:0] c1_o    [2];
    logic       s0_o    [2];
    logic       s1_o    [2];

    ro_count_window #(.CNT_W(4), .WIN_W(8), .WINDOW(16), .FLUSH(FL)) u_dut16 (
        .clk(clk), .reset(reset), .start(start), .ro0(ro0), .ro1(ro1),
        .ro_en(ro_en_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .count0(c0_o[0]), .count1(c1_o[0]), .sat0(s0_o[0]), .sat1(s1_o[0])
    );

    ro_count_window #(.CNT_W(4), .WIN_W(8), .WINDOW(64), .FLUSH(FL)) u_dut64 (
        .clk(clk), .reset(reset), .start(start), .ro0(ro0), .ro1(ro1),
        .ro_en(ro_en_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .count0(c0_o[1]), .count1(c1_o[1]), .sat0(s0_o[1]), .sat1(s1_o[1])
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d, required %0d (t=%0t)", nm, d, got, exp, $time);
        end
    endtask

    function automatic int win(input int d);
        return (d == 0) ? 16 : 64;
    endfunction

    // ---------------- reference model ----------------
    int  cyc = -1;
    bit  h0 [NC];
    bit  h1 [NC];
    bit  act [2];
    int  n_st [2];
    int  free_at [2];
    int  m0, m1;
    logic [3:0] e_c0 [2];
    logic [3:0] e_c1 [2];
    bit  e_s0 [2], e_s1 [2], e_done [2], e_busy [2], e_en [2];

    // A clk-sampled rise at sample j becomes a counted pulse if the cycle after
    // edge j+1 lies in the COUNT window, i.e. j+1 in [N+FL, N+FL+W-1].
    initial forever begin
        @(posedge clk);
        cyc++;
        if (cyc < NC) begin
            h0[cyc] = !reset && ro0;
            h1[cyc] = !reset && ro1;
        end
        for (int d = 0; d < 2; d++) begin
            e_done[d] = 1'b0;
            if (reset) begin
                act[d] = 1'b0; free_at[d] = 0;
                e_c0[d] = 4'd0; e_c1[d] = 4'd0; e_s0[d] = 1'b0; e_s1[d] = 1'b0;
                e_busy[d] = 1'b0; e_en[d] = 1'b0;
            end else begin
                if (act[d] && cyc == n_st[d] + FL + win(d) + 1) begin
                    m0 = 0; m1 = 0;
                    for (int k = n_st[d] + FL; k < n_st[d] + FL + win(d); k++) begin
                        if (h0[k-1] && !h0[k-2]) m0++;
                        if (h1[k-1] && !h1[k-2]) m1++;
                    end
                    e_c0[d] = (m0 >= 15) ? 4'd15 : 4'(m0);
                    e_c1[d] = (m1 >= 15) ? 4'd15 : 4'(m1);
                    e_s0[d] = (m0 >= 15);
                    e_s1[d] = (m1 >= 15);
                    e_done[d] = 1'b1;
                    act[d] = 1'b0;
                end
                if (!act[d] && start && cyc >= free_at[d]) begin
                    act[d] = 1'b1;
                    n_st[d] = cyc;
                    free_at[d] = cyc + FL + win(d) + 2;
                end
                e_busy[d] = act[d] && (cyc - n_st[d] <= FL + win(d));
                e_en[d]   = act[d] && (cyc - n_st[d] <  FL + win(d));
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #3;
        if (cyc >= 0) begin
            for (int d = 0; d < 2; d++) begin
                check("done",   d, done_o[d],  e_done[d]);
                check("busy",   d, busy_o[d],  e_busy[d]);
                check("ro_en",  d, ro_en_o[d], e_en[d]);
                check("count0", d, c0_o[d],    e_c0[d]);
                check("count1", d, c1_o[d],    e_c1[d]);
                check("sat0",   d, s0_o[d],    e_s0[d]);
                check("sat1",   d, s1_o[d],    e_s1[d]);
            end
        end
    end

    // ---------------- stimulus ----------------
    int per0 = 0, per1 = 0;
    bit lvl0 = 1'b0, lvl1 = 1'b0;
    int ph = 0;

    function automatic bit gen(input int per, input bit lvl, input int p);
        if (per < 0) return 1'($urandom % 2);
        if (per == 0) return lvl;
        return (p % per) < (per / 2);
    endfunction

    task automatic tick();
        @(negedge clk);
        ro0 = gen(per0, lvl0, ph);
        ro1 = gen(per1, lvl1, ph);
        ph++;
    endtask

    task automatic wait_done(input int d, input int max, output int at);
        bit ok;
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < max && !ok; i++) begin
            tick();
            if (done_o[d]) begin
                ok = 1'b1;
                at = cyc;
            end
        end
        check("done_timeout", d, ok, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 120 && !ok; i++) begin
            tick();
            ok = !busy_o[0] && !busy_o[1];
        end
        check("idle_timeout", 0, ok, 1);
    endtask

    task automatic pulse_start(output int n);
        start = 1'b1;
        n = cyc + 1;
        tick();
        start = 1'b0;
    endtask

    function automatic int pick();
        case ($urandom % 4)
            0:       return -1;
            1:       return 0;
            default: return int'($urandom_range(2, 9));
        endcase
    endfunction

    int n0, d0, d1, nd;

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // basic count: ro0 period 4, ro1 low
        per0 = 4; per1 = 0; lvl1 = 1'b0;
        repeat (6) tick();
        pulse_start(n0);
        wait_done(0, 60, d0);
        check("latency16", 0, d0 - n0, 20);
        check("basic_c0", 0, c0_o[0], 4);
        check("basic_c1", 0, c1_o[0], 0);
        check("basic_s0", 0, s0_o[0], 0);
        wait_done(1, 80, d1);
        check("latency64", 1, d1 - n0, 68);
        check("basic_c0", 1, c0_o[1], 15);
        check("basic_s0", 1, s0_o[1], 1);

        // saturation: ro0 period 2, ro1 period 8
        wait_idle();
        per0 = 2; per1 = 8;
        repeat (3) tick();
        pulse_start(n0);
        wait_done(0, 60, d0);
        check("sat_c0", 0, c0_o[0], 8);
        check("sat_c1", 0, c1_o[0], 2);
        wait_done(1, 80, d1);
        check("sat_c0", 1, c0_o[1], 15);
        check("sat_s0", 1, s0_o[1], 1);
        check("sat_c1", 1, c1_o[1], 8);
        check("sat_s1", 1, s1_o[1], 0);

        // reset mid-COUNT
        wait_idle();
        pulse_start(n0);
        repeat (10) tick();
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_busy", d, busy_o[d], 0);
            check("rst_en",   d, ro_en_o[d], 0);
            check("rst_c0",   d, c0_o[d], 0);
            check("rst_s0",   d, s0_o[d], 0);
        end
        repeat (3) tick();
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (done_o[0] || done_o[1]) nd++;
        end
        check("rst_no_done", 0, nd, 0);

        // start pulsed again during COUNT is ignored
        per0 = 4; per1 = 3;
        pulse_start(n0);
        repeat (8) tick();
        pulse_start(n0);
        nd = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done_o[0]) nd++;
        end
        check("ignored_start_dones", 0, nd, 1);

        // back-to-back with start held high
        wait_idle();
        per0 = 4; per1 = 0;
        start = 1'b1;
        n0 = cyc + 1;
        wait_done(0, 60, d0);
        check("b2b_latency", 0, d0 - n0, 20);
        check("b2b_first_c0", 0, c0_o[0], 4);
        per0 = 0; lvl0 = 1'b1;
        wait_done(0, 60, d1);
        check("b2b_spacing", 0, d1 - d0, 21);
        check("b2b_second_c0", 0, c0_o[0], 0);
        start = 1'b0;
        wait_idle();

        // edges only in IDLE and ARM
        per0 = 2;
        repeat (10) tick();
        per0 = 0; lvl0 = 1'b0;
        tick();
        start = 1'b1;
        lvl0 = 1'b1;
        tick();
        start = 1'b0;
        lvl0 = 1'b0;
        tick();
        wait_done(0, 60, d0);
        check("oow_c0", 0, c0_o[0], 0);
        wait_done(1, 80, d1);
        check("oow_c0", 1, c0_o[1], 0);

        // randomized traffic
        for (int r = 0; r < 25; r++) begin
            per0 = pick(); per1 = pick();
            lvl0 = 1'($urandom % 2); lvl1 = 1'($urandom % 2);
            start = 1'b1;
            repeat ($urandom_range(1, 30)) tick();
            start = 1'b0;
            repeat ($urandom_range(0, 90)) tick();
            if ($urandom % 8 == 0) begin
                reset = 1'b1;
                repeat (2) tick();
                reset = 1'b0;
            end
        end
        wait_idle();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
